// File: rtl/gcd_res_fifo.sv
// gcd_res_fifo: in-order result buffer behind the GCD unit.
// Tags every accepted result with a wrapping sequence number.
module gcd_res_fifo #(
    parameter int WL    = 8,
    parameter int DEPTH = 4,
    parameter int SEQW  = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_val,
    output logic            in_rdy,
    input  logic [WL-1:0]   in_res,
    output logic            out_val,
    input  logic            out_rdy,
    output logic [WL-1:0]   out_res,
    output logic [SEQW-1:0] out_seq,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty
);

    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic [SEQW-1:0] seq_ctr;
    logic [WL-1:0]   mem_res [DEPTH];
    logic [SEQW-1:0] mem_seq [DEPTH];
    logic            enq;
    logic            deq;

    // Status flags and handshakes depend only on registered count,
    // so neither ready nor valid ever loops through the other side.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign in_rdy  = !full;
    assign out_val = !empty;
    assign enq     = in_val && in_rdy;
    assign deq     = out_val && out_rdy;
    assign out_res = mem_res[rp];
    assign out_seq = mem_seq[rp];

    // Storage array: write the tagged result at wp on enqueue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_res[i] <= '0;
                mem_seq[i] <= '0;
            end
        end else if (enq) begin
            mem_res[wp] <= in_res;
            mem_seq[wp] <= seq_ctr;
        end
    end

    // Pointers, occupancy and sequence counter; DEPTH is a power of
    // two so the pointers wrap naturally at their width.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            seq_ctr <= '0;
        end else begin
            if (enq) begin
                wp      <= wp + 1'b1;
                seq_ctr <= seq_ctr + 1'b1;
            end
            if (deq) begin
                rp <= rp + 1'b1;
            end
            unique case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_res_fifo.sv
// tb_gcd_res_fifo: directed checks of the GCD result buffer.
// Inputs change and outputs are sampled 1 time unit after each edge.
module tb_gcd_res_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] in_res;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_res;
    logic [7:0] out_seq;
    logic [2:0] count;
    logic       full;
    logic       empty;

    int vectors = 0;
    int errors  = 0;

    gcd_res_fifo #(.WL(8), .DEPTH(4), .SEQW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_res  (in_res),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_res (out_res),
        .out_seq (out_seq),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        in_val  = 1'b0;
        out_rdy = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] sval(input int i);
        return 8'((i * 7 + 3) % 256);
    endfunction

    int   nin;
    int   nout;
    logic fire;
    int   fill_v [5] = '{5, 7, 9, 11, 13};

    initial begin
        rst     = 1'b1;
        in_val  = 1'b0;
        in_res  = '0;
        out_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // reset then idle
        check("rst_in_rdy",  int'(in_rdy),  1);
        check("rst_out_val", int'(out_val), 0);
        check("rst_count",   int'(count),   0);
        check("rst_empty",   int'(empty),   1);
        check("rst_full",    int'(full),    0);
        check("rst_out_res", int'(out_res), 0);
        check("rst_out_seq", int'(out_seq), 0);

        // single pass
        in_val = 1'b1;
        in_res = 8'd2;
        tick();
        in_val = 1'b0;
        check("sp_out_val", int'(out_val), 1);
        check("sp_out_res", int'(out_res), 2);
        check("sp_out_seq", int'(out_seq), 0);
        check("sp_count",   int'(count),   1);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        check("sp_empty", int'(empty), 1);

        // fill and backpressure
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_val = 1'b1;
            in_res = 8'(fill_v[i]);
            tick();
        end
        in_res = 8'(fill_v[4]);
        check("fill_full",   int'(full),   1);
        check("fill_in_rdy", int'(in_rdy), 0);
        check("fill_count",  int'(count),  4);
        tick();
        check("hold_count",  int'(count),  4);
        check("hold_head",   int'(out_res), 5);
        out_rdy = 1'b1;
        check("bp0_res", int'(out_res), 5);
        check("bp0_seq", int'(out_seq), 0);
        tick();
        check("bp1_res",    int'(out_res), 7);
        check("bp1_seq",    int'(out_seq), 1);
        check("bp1_in_rdy", int'(in_rdy),  1);
        check("bp1_count",  int'(count),   3);
        tick();
        in_val = 1'b0;
        check("bp2_res",   int'(out_res), 9);
        check("bp2_seq",   int'(out_seq), 2);
        check("bp2_count", int'(count),   3);
        tick();
        check("bp3_res",   int'(out_res), 11);
        check("bp3_seq",   int'(out_seq), 3);
        check("bp3_count", int'(count),   2);
        tick();
        check("bp4_res",   int'(out_res), 13);
        check("bp4_seq",   int'(out_seq), 4);
        check("bp4_count", int'(count),   1);
        tick();
        out_rdy = 1'b0;
        check("bp_drain_empty", int'(empty), 1);

        // streaming
        do_reset();
        nin     = 0;
        nout    = 0;
        in_val  = 1'b1;
        in_res  = sval(0);
        out_rdy = 1'b1;
        for (int c = 0; c < 400 && nout < 300; c++) begin
            if (out_val) begin
                check("st_res", int'(out_res), int'(sval(nout)));
                check("st_seq", int'(out_seq), nout % 256);
                if (nout == 256) check("st_seq_wrap", int'(out_seq), 0);
                nout++;
            end
            check("st_cnt_le1", int'(count <= 3'd1), 1);
            fire = in_val && in_rdy;
            tick();
            if (fire) begin
                nin++;
                if (nin == 300) in_val = 1'b0;
                else in_res = sval(nin);
            end
        end
        check("st_done", nout, 300);
        out_rdy = 1'b0;

        // simultaneous enqueue/dequeue at count 2
        do_reset();
        in_val = 1'b1;
        in_res = 8'd20;
        tick();
        in_res = 8'd30;
        tick();
        check("sim_pre_count", int'(count),   2);
        check("sim_pre_head",  int'(out_res), 20);
        in_res  = 8'd40;
        out_rdy = 1'b1;
        tick();
        in_val  = 1'b0;
        out_rdy = 1'b0;
        check("sim_count",    int'(count),   2);
        check("sim_head_res", int'(out_res), 30);
        check("sim_head_seq", int'(out_seq), 1);

        // reset mid-operation
        in_val = 1'b1;
        in_res = 8'd50;
        tick();
        check("mr_pre_count", int'(count), 3);
        rst    = 1'b1;
        in_res = 8'd99;
        tick();
        rst    = 1'b0;
        in_val = 1'b0;
        check("mr_count",   int'(count),   0);
        check("mr_out_val", int'(out_val), 0);
        in_val = 1'b1;
        in_res = 8'd77;
        tick();
        in_val = 1'b0;
        check("mr_new_res",   int'(out_res), 77);
        check("mr_new_seq",   int'(out_seq), 0);
        check("mr_new_count", int'(count),   1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
